apb_sram_ctrl: RTL and testbench

- APB4 slave that acts as the initiator on the team's 32-bit single-port SRAM port with 4-bit write byte enables.
- Converts APB read/write transfers into registered SRAM en/we/wbe/addr/din strobes and returns SRAM read data on PRDATA.
- Sits below the AHB2APB bridge as a memory peripheral; pairs 1:1 with one SRAM macro that has one cycle of read latency.

---
 rtl/apb_sram_pkg.sv | 19 +
 rtl/apb_sram_ctrl.sv | 143 ++++++++++++++
 tb/tb_apb_sram_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_sram_pkg.sv
// Shared types and constants for the APB-to-SRAM controller.
// Optional range check state is compiled in with APB_SRAM_RANGE_CHK_EN.
package apb_sram_pkg;

    localparam int APB_STRB_W = 4;
    localparam int BYTE_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_DATA = 3'd3
`ifdef APB_SRAM_RANGE_CHK_EN
        ,
        ST_ERR     = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/apb_sram_ctrl.sv
// APB4 slave driving a single-port 32-bit SRAM; range check via APB_SRAM_RANGE_CHK_EN.
// Latency: write completes in 2 cycles (setup + access), read in 3 (one wait state).
// Backpressure: pready low only in RD_REQ while the SRAM read is in flight; no other stalls.
module apb_sram_ctrl
    import apb_sram_pkg::*;
#(
    parameter int ADDR_BITS   = 7,
    parameter int ADDR_AMOUNT = 128,
    parameter int DATA_BITS   = 32,
    parameter int PADDR_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [PADDR_BITS-1:0] paddr,
    input  logic [DATA_BITS-1:0]  pwdata,
    input  logic [APB_STRB_W-1:0] pstrb,
    output logic [DATA_BITS-1:0]  prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [APB_STRB_W-1:0] sram_wbe,
    output logic [ADDR_BITS-1:0]  sram_addr,
    output logic [DATA_BITS-1:0]  sram_din,
    input  logic [DATA_BITS-1:0]  sram_dout
);

    state_t                  state_q, state_d;
    logic                    en_q, en_d;
    logic                    we_q, we_d;
    logic [APB_STRB_W-1:0]   wbe_q, wbe_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [DATA_BITS-1:0]    din_q, din_d;

    logic                    setup;
    logic                    range_err;
    logic                    accept;
    logic [ADDR_BITS-1:0]    word_idx;

    assign setup    = psel && !penable;
    assign word_idx = paddr[ADDR_BITS+1:2];

`ifdef APB_SRAM_RANGE_CHK_EN
    assign range_err = (32'(word_idx) >= ADDR_AMOUNT) || (|paddr[PADDR_BITS-1:ADDR_BITS+2]);
    logic unused_paddr;
    assign unused_paddr = ^paddr[1:0];
`else
    // Byte offset and high address bits are dropped: accesses wrap modulo the SRAM depth.
    assign range_err = 1'b0;
    logic unused_paddr;
    assign unused_paddr = ^{paddr[1:0], paddr[PADDR_BITS-1:ADDR_BITS+2]};
`endif

    assign accept = (state_q == ST_IDLE) && setup && !range_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    state_d = pwrite ? ST_WR : ST_RD_REQ;
`ifdef APB_SRAM_RANGE_CHK_EN
                    if (range_err) state_d = ST_ERR;
`endif
                end
            end
            ST_WR:      state_d = ST_IDLE;
            ST_RD_REQ:  state_d = ST_RD_DATA;
            ST_RD_DATA: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        case (state_q)
            ST_WR:      pready = 1'b1;
            ST_RD_DATA: begin
                pready = 1'b1;
                prdata = sram_dout;
            end
`ifdef APB_SRAM_RANGE_CHK_EN
            ST_ERR: begin
                pready  = 1'b1;
                pslverr = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Strobes live for exactly one cycle after an accepted setup, then clear.
    always_comb begin
        en_d   = 1'b0;
        we_d   = 1'b0;
        wbe_d  = '0;
        addr_d = '0;
        din_d  = '0;
        if (accept) begin
            en_d   = 1'b1;
            we_d   = pwrite;
            wbe_d  = pwrite ? pstrb : '0;
            addr_d = word_idx;
            din_d  = pwrite ? pwdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q   <= 1'b0;
            we_q   <= 1'b0;
            wbe_q  <= '0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            en_q   <= en_d;
            we_q   <= we_d;
            wbe_q  <= wbe_d;
            addr_q <= addr_d;
            din_q  <= din_d;
        end
    end

    assign sram_en   = en_q;
    assign sram_we   = we_q;
    assign sram_wbe  = wbe_q;
    assign sram_addr = addr_q;
    assign sram_din  = din_q;

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Directed bench for apb_sram_ctrl with a behavioural one-cycle-latency SRAM beside it.
// Expected read data is queued at setup and checked when pready completes the read.
module tb_apb_sram_ctrl;

`ifdef APB_SRAM_RANGE_CHK_EN
    localparam int AMT = 100;
`else
    localparam int AMT = 128;
`endif
    localparam int AB = 7;

    logic        clk = 1'b0;
    logic        rstn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        sram_en, sram_we;
    logic [3:0]  sram_wbe;
    logic [6:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    int tests = 0;
    int fails = 0;
    int en_cnt = 0;
    logic [31:0] sb[$];
    logic [31:0] mem[128];

    always #5 clk = ~clk;

    apb_sram_ctrl #(
        .ADDR_BITS(AB), .ADDR_AMOUNT(AMT), .DATA_BITS(32), .PADDR_BITS(32)
    ) dut (
        .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .sram_en(sram_en), .sram_we(sram_we),
        .sram_wbe(sram_wbe), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout)
    );

    initial begin
        foreach (mem[i]) mem[i] = 32'h0;
        sram_dout = 32'h0;
    end

    always @(posedge clk) begin
        if (sram_en) begin
            en_cnt <= en_cnt + 1;
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wbe[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        check("idle_pready", {31'b0, pready}, 32'h0);
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [31:0] exp_rd,
                            input int exp_waits, input logic exp_err);
        int waits;
        logic [31:0] exp;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        if (!wr) sb.push_back(exp_rd);
        @(negedge clk);
        penable = 1'b1;
        if (exp_err) begin
            check("err_sram_en", {31'b0, sram_en}, 32'h0);
        end else begin
            check("t1_sram_en", {31'b0, sram_en}, 32'h1);
            check("t1_sram_we", {31'b0, sram_we}, {31'b0, wr});
            check("t1_sram_addr", {25'b0, sram_addr}, (addr >> 2) & 32'h7F);
            if (wr) begin
                check("t1_sram_wbe", {28'b0, sram_wbe}, {28'b0, strb});
                check("t1_sram_din", sram_din, data);
            end
        end
        waits = 0;
        while (!pready && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        check("pready_waits", waits, exp_waits);
        check("pslverr", {31'b0, pslverr}, {31'b0, exp_err});
        if (!wr) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'h1, 32'h0);
            end else begin
                exp = sb.pop_front();
                check("prdata", prdata, exp);
            end
        end
    endtask

    initial begin
        int en_before;
        rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (2) @(negedge clk);
        check("rst_sram_en",   {31'b0, sram_en}, 32'h0);
        check("rst_sram_we",   {31'b0, sram_we}, 32'h0);
        check("rst_sram_wbe",  {28'b0, sram_wbe}, 32'h0);
        check("rst_sram_addr", {25'b0, sram_addr}, 32'h0);
        check("rst_sram_din",  sram_din, 32'h0);
        check("rst_prdata",    prdata, 32'h0);
        check("rst_pready",    {31'b0, pready}, 32'h0);
        check("rst_pslverr",   {31'b0, pslverr}, 32'h0);
        rstn = 1'b1;

        // full write then read
        apb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 1'b0);
        idle();
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1, 1'b0);
        idle();
        check("idle_prdata", prdata, 32'h0);

        // partial strobes, issued back to back
        apb_xfer(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 1'b0);
        apb_xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 1'b0);
        apb_xfer(1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1, 1'b0);
        idle();

        // back-to-back mix with no idle cycles
        apb_xfer(1'b1, 32'h0, 32'hA5A50000, 4'hF, 32'h0, 0, 1'b0);
        apb_xfer(1'b1, 32'h4, 32'h5A5A1111, 4'hF, 32'h0, 0, 1'b0);
        apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A50000, 1, 1'b0);
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, 32'h5A5A1111, 1, 1'b0);
        idle();

        // zero strobe write leaves memory untouched
        apb_xfer(1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, 32'h0, 0, 1'b0);
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, 32'h5A5A1111, 1, 1'b0);
        idle();

        // unaligned byte address truncates to the word
        apb_xfer(1'b0, 32'h13, 32'h0, 4'h0, 32'hDEADBEEF, 1, 1'b0);
        idle();

`ifndef APB_SRAM_RANGE_CHK_EN
        apb_xfer(1'b0, 32'h200, 32'h0, 4'h0, 32'hA5A50000, 1, 1'b0);
        idle();
`endif

        // penable without setup is ignored
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h10;
        repeat (2) begin
            @(negedge clk);
            check("nosetup_pready", {31'b0, pready}, 32'h0);
            check("nosetup_sram_en", {31'b0, sram_en}, 32'h0);
        end
        idle();

        // reset asserted while in RD_REQ
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
        @(negedge clk);
        penable = 1'b1;
        check("rdreq_sram_en", {31'b0, sram_en}, 32'h1);
        #1 rstn = 1'b0;
        #1;
        check("midrst_sram_en", {31'b0, sram_en}, 32'h0);
        check("midrst_pready", {31'b0, pready}, 32'h0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("postrst_pready", {31'b0, pready}, 32'h0);
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1, 1'b0);
        idle();

`ifdef APB_SRAM_RANGE_CHK_EN
        en_before = en_cnt;
        apb_xfer(1'b0, 32'h190, 32'h0, 4'h0, 32'h0, 0, 1'b1);
        idle();
        apb_xfer(1'b1, 32'h400, 32'h12345678, 4'hF, 32'h0, 0, 1'b1);
        idle();
        check("range_no_sram_en", en_cnt, en_before);
        apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A50000, 1, 1'b0);
        idle();
`else
        en_before = en_cnt;
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, 32'h5A5A1111, 1, 1'b0);
        idle();
        check("read_one_sram_cycle", en_cnt, en_before + 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
